// File: rtl/cpu_reset_sequencer_pkg.sv
// Shared types and helpers for the CPU reset sequencer.
// State encodings match the values used by the other clock/reset blocks.
package cpu_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_POR_HOLD  = 2'd1,
    S_SYS_HOLD  = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam int LOSS_W = 8;

  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A hold length is usable when it is nonzero and its terminal value fits the counter.
  function automatic bit hold_fits(input int value, input int width);
    return (value >= 1) && (longint'(value - 1) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/cpu_reset_sequencer_cdc_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous flag, cleared asynchronously.
module cdc_sync_2ff (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_reset_sequencer.sv
// Cortex-M reset pair sequencer: waits for a stable clock lock, releases poresetn,
// then sysresetn, and re-sequences on lock loss or system reset requests.
//
// state       | meaning
// S_WAIT_LOCK | both resets low, counting consecutive synced-lock cycles
// S_POR_HOLD  | lock stable, both resets still low for POR_HOLD_CYCLES
// S_SYS_HOLD  | poresetn high, sysresetn low for SYS_HOLD_CYCLES
// S_RUN       | both resets high, CPU running
module cpu_reset_sequencer
  import cpu_reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int POR_HOLD_CYCLES    = 16,
  parameter int SYS_HOLD_CYCLES    = 16,
  parameter int CNT_W              = 16
) (
  input  logic              clk_cpu,
  input  logic              resetn,
  input  logic              locked,
  input  logic              sysresetreq,
  input  logic              sw_reset_req,
  output logic              poresetn,
  output logic              sysresetn,
  output logic              cpu_ready,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  if (!hold_fits(LOCK_STABLE_CYCLES, CNT_W)) begin : g_bad_lock
    $error("LOCK_STABLE_CYCLES must be >= 1 and fit in CNT_W bits");
  end
  if (!hold_fits(POR_HOLD_CYCLES, CNT_W)) begin : g_bad_por
    $error("POR_HOLD_CYCLES must be >= 1 and fit in CNT_W bits");
  end
  if (!hold_fits(SYS_HOLD_CYCLES, CNT_W)) begin : g_bad_sys
    $error("SYS_HOLD_CYCLES must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POR_TC  = CNT_W'(POR_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_TC  = CNT_W'(SYS_HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;
  logic             req;

  cdc_sync_2ff u_lock_sync (
    .clk   (clk_cpu),
    .clr_n (resetn),
    .d     (locked),
    .q     (locked_s)
  );

  // Both request sources lead to the same action; lock loss outranks them below.
  assign req = sysresetreq | sw_reset_req;

  always_ff @(posedge clk_cpu or negedge resetn) begin
    if (!resetn) begin
      state         <= S_WAIT_LOCK;
      cnt           <= '0;
      poresetn      <= 1'b0;
      sysresetn     <= 1'b0;
      cpu_ready     <= 1'b0;
      lock_loss_cnt <= '0;
    end else if (state != S_WAIT_LOCK && !locked_s) begin
      state     <= S_WAIT_LOCK;
      cnt       <= '0;
      poresetn  <= 1'b0;
      sysresetn <= 1'b0;
      cpu_ready <= 1'b0;
      if (poresetn) lock_loss_cnt <= sat_inc(lock_loss_cnt);
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          poresetn  <= 1'b0;
          sysresetn <= 1'b0;
          cpu_ready <= 1'b0;
          if (!locked_s) begin
            cnt <= '0;
          end else if (cnt == LOCK_TC) begin
            state <= S_POR_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_POR_HOLD: begin
          if (cnt == POR_TC) begin
            state    <= S_SYS_HOLD;
            cnt      <= '0;
            poresetn <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SYS_HOLD: begin
          if (req) begin
            cnt <= '0;
          end else if (cnt == SYS_TC) begin
            state     <= S_RUN;
            cnt       <= '0;
            sysresetn <= 1'b1;
            cpu_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (req) begin
            state     <= S_SYS_HOLD;
            cnt       <= '0;
            sysresetn <= 1'b0;
            cpu_ready <= 1'b0;
          end
        end
        default: begin
          state     <= S_WAIT_LOCK;
          cnt       <= '0;
          poresetn  <= 1'b0;
          sysresetn <= 1'b0;
          cpu_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Directed bench for cpu_reset_sequencer with a timestamp-based reference model.
module tb_cpu_reset_sequencer;

  localparam int LOCK = 4;
  localparam int POR  = 3;
  localparam int SYS  = 2;

  logic       clk_cpu = 1'b0;
  logic       resetn;
  logic       locked;
  logic       sysresetreq;
  logic       sw_reset_req;
  logic       poresetn;
  logic       sysresetn;
  logic       cpu_ready;
  logic [7:0] lock_loss_cnt;

  int vectors = 0;
  int miscompares = 0;

  cpu_reset_sequencer #(
    .LOCK_STABLE_CYCLES (LOCK),
    .POR_HOLD_CYCLES    (POR),
    .SYS_HOLD_CYCLES    (SYS),
    .CNT_W              (16)
  ) dut (
    .clk_cpu       (clk_cpu),
    .resetn        (resetn),
    .locked        (locked),
    .sysresetreq   (sysresetreq),
    .sw_reset_req  (sw_reset_req),
    .poresetn      (poresetn),
    .sysresetn     (sysresetn),
    .cpu_ready     (cpu_ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks when the lock became stable and when sysresetn is due,
  // and derives the outputs from those timestamps.
  int m_n, m_run, m_tlock, m_tsys, m_loss;
  bit m_por, m_sys;
  int m_hist[$];

  always @(posedge clk_cpu) begin
    int ls;
    bit pp;
    if (!resetn) begin
      m_n = 0; m_run = 0; m_tlock = -1; m_tsys = 0; m_loss = 0;
      m_por = 0; m_sys = 0;
      m_hist = '{0, 0};
    end else begin
      m_n++;
      ls = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(int'(locked));
      pp = m_por;
      if (m_tlock < 0) begin
        if (ls != 0) m_run++; else m_run = 0;
        if (m_run == LOCK) begin
          m_tlock = m_n;
          m_tsys  = m_n + POR + SYS;
        end
      end else if (ls == 0) begin
        if (pp && m_loss < 255) m_loss++;
        m_tlock = -1;
        m_run   = 0;
      end else if ((sysresetreq || sw_reset_req) && pp) begin
        m_tsys = m_n + SYS;
      end
      m_por = (m_tlock >= 0) && (m_n >= m_tlock + POR);
      m_sys = (m_tlock >= 0) && (m_n >= m_tsys);
    end
    #2;
    chk("model poresetn", int'(poresetn), int'(m_por));
    chk("model sysresetn", int'(sysresetn), int'(m_sys));
    chk("model cpu_ready", int'(cpu_ready), int'(m_sys));
    chk("model lock_loss_cnt", int'(lock_loss_cnt), m_loss);
  end

  task automatic step();
    @(negedge clk_cpu);
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    #1;
    chk("reset poresetn", int'(poresetn), 0);
    chk("reset sysresetn", int'(sysresetn), 0);
    chk("reset cpu_ready", int'(cpu_ready), 0);
    chk("reset lock_loss_cnt", int'(lock_loss_cnt), 0);
    @(negedge clk_cpu);
    resetn = 1'b1;
  endtask

  task automatic wait_run();
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (cpu_ready) hit = 1;
    end
    chk("wait_run reached", int'(hit), 1);
  endtask

  task automatic wait_por();
    bit hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (poresetn) hit = 1;
    end
    chk("wait_por reached", int'(hit), 1);
  endtask

  initial begin
    locked = 1'b0; sysresetreq = 1'b0; sw_reset_req = 1'b0;

    // 1: locked high from release; poresetn at edge 9, sysresetn/cpu_ready at edge 11
    reset_dut();
    locked = 1'b1;
    repeat (8) step();
    chk("t1 poresetn edge8", int'(poresetn), 0);
    step();
    chk("t1 poresetn edge9", int'(poresetn), 1);
    chk("t1 sysresetn edge9", int'(sysresetn), 0);
    step();
    chk("t1 sysresetn edge10", int'(sysresetn), 0);
    step();
    chk("t1 sysresetn edge11", int'(sysresetn), 1);
    chk("t1 cpu_ready edge11", int'(cpu_ready), 1);

    // 2: 1,1,1,0 lock pattern never reaches the stable count
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      locked = (i % 4 != 3);
      step();
      chk("t2 poresetn", int'(poresetn), 0);
      chk("t2 sysresetn", int'(sysresetn), 0);
    end
    locked = 1'b1;
    wait_run();

    // 3: software reset pulse from S_RUN
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    chk("t3 sysresetn c0", int'(sysresetn), 0);
    chk("t3 poresetn c0", int'(poresetn), 1);
    step();
    chk("t3 sysresetn c1", int'(sysresetn), 0);
    step();
    chk("t3 sysresetn c2", int'(sysresetn), 1);
    chk("t3 poresetn c2", int'(poresetn), 1);
    chk("t3 lock_loss_cnt", int'(lock_loss_cnt), 0);

    // 4: lock loss in S_RUN, then recovery
    locked = 1'b0;
    step();
    chk("t4 poresetn a", int'(poresetn), 1);
    step();
    chk("t4 poresetn a1", int'(poresetn), 1);
    step();
    chk("t4 poresetn a2", int'(poresetn), 0);
    chk("t4 sysresetn a2", int'(sysresetn), 0);
    chk("t4 lock_loss_cnt", int'(lock_loss_cnt), 1);
    locked = 1'b1;
    repeat (8) step();
    chk("t4 poresetn b7", int'(poresetn), 0);
    step();
    chk("t4 poresetn b8", int'(poresetn), 1);
    step();
    chk("t4 sysresetn b9", int'(sysresetn), 0);
    step();
    chk("t4 sysresetn b10", int'(sysresetn), 1);

    // 5: lock loss beats a held sysresetreq in S_SYS_HOLD; held request keeps sysresetn low
    sysresetreq = 1'b1;
    step();
    locked = 1'b0;
    step();
    step();
    chk("t5 sysresetn held", int'(sysresetn), 0);
    chk("t5 poresetn held", int'(poresetn), 1);
    step();
    chk("t5 poresetn loss", int'(poresetn), 0);
    chk("t5 lock_loss_cnt", int'(lock_loss_cnt), 2);
    locked = 1'b1;
    repeat (8) step();
    chk("t5 poresetn rearm b7", int'(poresetn), 0);
    step();
    chk("t5 poresetn rearm b8", int'(poresetn), 1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5 sysresetn req held", int'(sysresetn), 0);
    end
    sysresetreq = 1'b0;
    step();
    chk("t5 sysresetn after req", int'(sysresetn), 0);
    step();
    chk("t5 sysresetn release", int'(sysresetn), 1);

    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      wait_por();
      locked = 1'b0;
      repeat (3) step();
    end
    chk("t5 lock_loss_cnt saturated", int'(lock_loss_cnt), 255);

    // 6: async reset in the middle of S_SYS_HOLD
    locked = 1'b1;
    wait_run();
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6 async poresetn", int'(poresetn), 0);
    chk("t6 async sysresetn", int'(sysresetn), 0);
    chk("t6 async cpu_ready", int'(cpu_ready), 0);
    chk("t6 async lock_loss_cnt", int'(lock_loss_cnt), 0);
    @(negedge clk_cpu);
    resetn = 1'b1;
    repeat (8) step();
    chk("t6 poresetn edge8", int'(poresetn), 0);
    step();
    chk("t6 poresetn edge9", int'(poresetn), 1);
    repeat (2) step();
    chk("t6 cpu_ready edge11", int'(cpu_ready), 1);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
